kbd_matrix_scanner: RTL

KBD_MATRIX_SCANNER -- requirements
Module: kbd_matrix_scanner

---
 rtl/kbd_matrix_scanner_pkg.sv | 27 ++
 rtl/kbd_evt_fifo.sv | 44 ++++
 rtl/kbd_matrix_scanner.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/kbd_matrix_scanner_pkg.sv
// Shared types and field widths for the keyboard matrix scanner and its event FIFO.
package kbd_matrix_scanner_pkg;

    localparam int unsigned KBD_ROWS  = 9;
    localparam int unsigned KBD_COLS  = 10;
    localparam int unsigned KBD_RW    = $clog2(KBD_ROWS);
    localparam int unsigned KBD_CW    = $clog2(KBD_COLS);
    localparam int unsigned KBD_EVT_W = 1 + KBD_RW + KBD_CW;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned SETTLE_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_COMPARE,
        S_NEXT
    } scan_state_e;

    // Event record as it appears on evt_data for the default matrix size
    typedef struct packed {
        logic              pressed;
        logic [KBD_RW-1:0] row;
        logic [KBD_CW-1:0] col;
    } kbd_evt_t;

endpackage

// File: rtl/kbd_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is taken only alongside a pop.
module kbd_evt_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/kbd_matrix_scanner.sv
// Column-driven key matrix scanner with per-key scan-count debounce and a queued event output.
module kbd_matrix_scanner
    import kbd_matrix_scanner_pkg::*;
#(
    parameter int unsigned ROWS           = KBD_ROWS,
    parameter int unsigned COLS           = KBD_COLS,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned FIFO_DEPTH     = 8,
    localparam int unsigned RW            = $clog2(ROWS),
    localparam int unsigned CW            = $clog2(COLS),
    localparam int unsigned EVT_W         = 1 + RW + CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_tick,
    input  logic [ROWS-1:0]  kbd_row,
    output logic [COLS-1:0]  kbd_col,
    output logic             evt_valid,
    output logic [EVT_W-1:0] evt_data,
    input  logic             evt_ready,
    output logic             evt_overflow,
    input  logic             clr_overflow,
    output logic             scan_busy
);

    localparam int unsigned KEYS = ROWS * COLS;
    localparam int unsigned KW   = $clog2(KEYS);

    scan_state_e         r_state, w_state_nxt;
    logic [CW-1:0]       r_col, w_col_nxt;
    logic [RW-1:0]       r_row, w_row_nxt;
    logic [SETTLE_W-1:0] r_settle, w_settle_nxt;
    logic [COLS-1:0]     r_kbd_col, w_kbd_col_nxt;
    logic                r_busy;
    logic                r_ovf;
    logic [ROWS-1:0]     r_snap;
    logic [KEYS-1:0]     r_deb;
    logic [CNT_W-1:0]    r_cnt [KEYS];

    logic [KW-1:0]       w_idx;
    logic                w_raw;
    logic                w_diff;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_push;
    logic                w_pop;
    logic                w_accept;
    logic                w_full;
    logic                w_empty;

    // Scan sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_settle  <= '0;
            r_kbd_col <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_settle  <= w_settle_nxt;
            r_kbd_col <= w_kbd_col_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_settle_nxt  = r_settle;
        w_kbd_col_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (scan_tick) begin
                    w_state_nxt  = S_DRIVE;
                    w_col_nxt    = '0;
                    w_settle_nxt = '0;
                end
            end
            S_DRIVE: begin
                if (r_settle == SETTLE_W'(SETTLE_CYCLES - 1)) w_state_nxt = S_SAMPLE;
                else                                          w_settle_nxt = r_settle + 1'b1;
            end
            S_SAMPLE: begin
                w_state_nxt = S_COMPARE;
                w_row_nxt   = '0;
            end
            S_COMPARE: begin
                if (r_row == RW'(ROWS - 1)) w_state_nxt = S_NEXT;
                else                        w_row_nxt   = r_row + 1'b1;
            end
            S_NEXT: begin
                w_settle_nxt = '0;
                if (r_col == CW'(COLS - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRIVE;
                    w_col_nxt   = r_col + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Column is released during NEXT so adjacent columns never overlap
        if (w_state_nxt inside {S_DRIVE, S_SAMPLE, S_COMPARE})
            w_kbd_col_nxt = COLS'(1) << w_col_nxt;
    end

    assign w_idx     = KW'(r_row) * KW'(COLS) + KW'(r_col);
    assign w_raw     = r_snap[r_row];
    assign w_diff    = (r_state == S_COMPARE) && (w_raw != r_deb[w_idx]);
    assign w_cnt_inc = (r_cnt[w_idx] == CNT_W'(DEBOUNCE_SCANS)) ? r_cnt[w_idx] : r_cnt[w_idx] + 1'b1;
    assign w_push    = w_diff && (w_cnt_inc == CNT_W'(DEBOUNCE_SCANS));
    assign w_pop     = evt_valid && evt_ready;
    assign w_accept  = w_push && (!w_full || w_pop);

    // Per-key debounce; a rejected event leaves the counter saturated so it retries next scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap <= '0;
            r_deb  <= '0;
            r_ovf  <= 1'b0;
            for (int k = 0; k < KEYS; k++) r_cnt[k] <= '0;
        end else begin
            if (r_state == S_SAMPLE) r_snap <= kbd_row;
            if (r_state == S_COMPARE) begin
                if (!w_diff) begin
                    r_cnt[w_idx] <= '0;
                end else if (w_accept) begin
                    r_deb[w_idx] <= w_raw;
                    r_cnt[w_idx] <= '0;
                end else begin
                    r_cnt[w_idx] <= w_cnt_inc;
                end
            end
            if (w_push && !w_accept) r_ovf <= 1'b1;
            else if (clr_overflow)   r_ovf <= 1'b0;
        end
    end

    kbd_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  ({w_raw, r_row, r_col}),
        .i_pop   (w_pop),
        .o_data  (evt_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign evt_valid    = !w_empty;
    assign kbd_col      = r_kbd_col;
    assign scan_busy    = r_busy;
    assign evt_overflow = r_ovf;

endmodule
